// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: PC / IF-ID / ID-EX sequencing for the RV32I 5-stage core (load-use, mispredict, fetch wait, dmem busy).
// Latency: control outputs are combinational from state + inputs (0 cycles); perf counters update on the next edge.
// Backpressure: dmem_busy freezes the whole pipe and holds state; load-use and fetch wait stall the front end.
module pipeline_hazard_ctrl #(
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mispredict,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RST      = 2'd0,
        ST_RUN      = 2'd1,
        ST_LU_STALL = 2'd2
    } state_t;

    // First load-use bubble is issued from RUN, the rest are counted down in LU_STALL.
    localparam logic [2:0] CNT_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             flush_taken;

    // Load-use hazard: EX load writes a register the ID instruction reads; x0 never hazards.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Next-state and prioritised pipeline control outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        flush_taken = 1'b0;
        if (state_q == ST_RST) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_RUN;
        end else if (dmem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (ex_mispredict) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_taken = 1'b1;
            state_d     = ST_RUN;
        end else if (state_q == ST_LU_STALL) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (cnt_q == 3'd0) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = ST_LU_STALL;
                cnt_d   = CNT_INIT;
            end
        end else if (!imem_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    // Saturating perf counters; clear beats increment, the reset cycle is not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if ((state_q != ST_RST) && !pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_taken && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    // State, countdown and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RST;
            cnt_q       <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: directed-vector scoreboard bench for pipeline_hazard_ctrl (main instance plus a narrow-counter instance).
// Latency: expectations are checked mid-cycle, half a period after the inputs are applied.
// Backpressure: none; the monitor pops one expectation per falling edge while the queue is non-empty.
module tb_pipeline_hazard_ctrl;

    localparam logic [4:0] O_RST = 5'b01110;  // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze}
    localparam logic [4:0] O_RUN = 5'b11000;
    localparam logic [4:0] O_LU  = 5'b00010;
    localparam logic [4:0] O_FRZ = 5'b00001;
    localparam logic [4:0] O_MP  = 5'b11110;
    localparam logic [4:0] O_IM  = 5'b01100;

    typedef struct packed {
        logic [4:0]  o;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic        ex_mispredict = 1'b0, imem_ready = 1'b1, dmem_busy = 1'b0, perf_clr = 1'b0;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_pipe_freeze;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_LAT(2), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_mispredict(ex_mispredict), .imem_ready(imem_ready),
        .dmem_busy(dmem_busy), .perf_clr(perf_clr), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pipe_freeze(pipe_freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow counters so saturation is reachable in a short run.
    pipeline_hazard_ctrl #(.LOAD_LAT(2), .CNT_W(3)) dut_sat (
        .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_mispredict(ex_mispredict), .imem_ready(imem_ready),
        .dmem_busy(dmem_busy), .perf_clr(perf_clr), .pc_write(s_pc_write),
        .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .pipe_freeze(s_pipe_freeze), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // hz: 0 none, 1 rs1 load-use on x5, 2 load to x0 read by rs1, 3 rs2 load-use on x7.
    task automatic step(input logic rn, input int hz, input logic mp, input logic imr,
                        input logic busy, input logic clr,
                        input logic [4:0] eo, input int esc, input int efc);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n       = rn;
        ex_mispredict = mp;
        imem_ready    = imr;
        dmem_busy     = busy;
        perf_clr      = clr;
        ex_mem_read   = (hz != 0);
        id_use_rs1    = (hz == 1) || (hz == 2) || (hz == 3);
        id_use_rs2    = (hz == 3);
        id_rs1        = (hz == 1) ? 5'd5 : (hz == 3) ? 5'd3 : 5'd0;
        id_rs2        = (hz == 3) ? 5'd7 : 5'd0;
        ex_rd         = (hz == 1) ? 5'd5 : (hz == 3) ? 5'd7 : 5'd0;
        e.o  = eo;
        e.sc = 16'(esc);
        e.fc = 16'(efc);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every observable output against the queued expectation.
    initial begin
        exp_t e;
        logic [4:0] got, sgot;
        logic [15:0] sexp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                got  = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze};
                sgot = {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_pipe_freeze};
                sexp = (e.sc > 16'd7) ? 16'd7 : e.sc;
                checks += 4;
                if (got !== e.o || sgot !== e.o) begin
                    errors++;
                    $display("FAIL ctrl t=%0t got=%b narrow=%b want=%b", $time, got, sgot, e.o);
                end
                if (stall_cnt !== e.sc) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.sc);
                end
                if (flush_cnt !== e.fc) begin
                    errors++;
                    $display("FAIL flush_cnt t=%0t got=%0d want=%0d", $time, flush_cnt, e.fc);
                end
                if ({13'd0, s_stall_cnt} !== sexp || {13'd0, s_flush_cnt} !== e.fc) begin
                    errors++;
                    $display("FAIL sat_cnt t=%0t stall got=%0d want=%0d flush got=%0d want=%0d",
                             $time, s_stall_cnt, sexp, s_flush_cnt, e.fc);
                end
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        int wait_cyc;
        repeat (2) @(posedge clk);
        //   rn hz mp imr busy clr  outputs  sc  fc
        step(0, 0, 0, 1, 0, 0, O_RST, 0, 0);   // held in reset
        step(1, 0, 0, 1, 0, 0, O_RST, 0, 0);   // RST cycle after release
        step(1, 0, 0, 1, 0, 0, O_RUN, 0, 0);
        step(1, 1, 0, 1, 0, 0, O_LU,  0, 0);   // load-use: bubble 1 from RUN
        step(1, 1, 0, 1, 0, 0, O_LU,  1, 0);   // bubble 2 in LU_STALL
        step(1, 0, 0, 1, 0, 0, O_RUN, 2, 0);
        step(1, 2, 0, 1, 0, 0, O_RUN, 2, 0);   // x0 never hazards
        step(1, 3, 0, 1, 0, 0, O_LU,  2, 0);   // rs2 hazard
        step(1, 0, 0, 1, 0, 0, O_LU,  3, 0);
        step(1, 0, 0, 1, 0, 0, O_RUN, 4, 0);
        step(1, 1, 0, 1, 0, 0, O_LU,  4, 0);
        step(1, 0, 1, 1, 0, 0, O_MP,  5, 0);   // mispredict aborts LU_STALL
        step(1, 0, 0, 1, 0, 0, O_RUN, 5, 1);
        step(1, 1, 0, 1, 0, 0, O_LU,  5, 1);
        step(1, 0, 0, 1, 1, 0, O_FRZ, 6, 1);   // dmem busy x3 inside LU_STALL
        step(1, 0, 0, 1, 1, 0, O_FRZ, 7, 1);
        step(1, 0, 0, 1, 1, 0, O_FRZ, 8, 1);
        step(1, 0, 0, 1, 0, 0, O_LU,  9, 1);   // stall resumes
        step(1, 0, 0, 1, 0, 0, O_RUN, 10, 1);
        step(1, 0, 1, 1, 1, 0, O_FRZ, 10, 1);  // busy outranks mispredict, no flush counted
        step(1, 0, 0, 1, 0, 0, O_RUN, 11, 1);
        step(1, 0, 0, 0, 0, 0, O_IM,  11, 1);  // fetch wait x2
        step(1, 0, 0, 0, 0, 0, O_IM,  12, 1);
        step(1, 0, 0, 1, 0, 0, O_RUN, 13, 1);
        step(1, 1, 0, 0, 0, 0, O_LU,  13, 1);  // hazard outranks fetch wait
        step(1, 0, 0, 0, 0, 0, O_LU,  14, 1);  // LU_STALL outranks fetch wait
        step(1, 1, 1, 1, 0, 0, O_MP,  15, 1);  // mispredict outranks hazard
        step(1, 0, 0, 0, 0, 1, O_IM,  15, 2);  // clear wins over increment
        step(1, 0, 0, 1, 0, 0, O_RUN, 0, 0);
        step(1, 1, 0, 1, 0, 0, O_LU,  0, 0);
        step(0, 1, 0, 1, 0, 0, O_RST, 0, 0);   // async reset mid LU_STALL
        step(1, 1, 0, 1, 0, 0, O_RST, 0, 0);   // hazard ignored in RST
        step(1, 0, 0, 1, 0, 0, O_RUN, 0, 0);
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
